// File: rtl/tdm_mux8_pkg.sv
// Shared types and constants for the 8-slot TDM transmitter.
package tdm_mux8_pkg;

  localparam int SLOT_COUNT = 8;
  localparam int SLOT_W     = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_hold_cnt.sv
// Per-slot hold counter: counts enabled cycles within a slot and flags the
// last hold cycle. Clear has priority over counting.
module tdm_hold_cnt #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tc
);

  localparam logic [3:0] TC_VAL = 4'(HOLD_CYCLES - 1);

  logic [3:0] r_cnt;

  // Advance the count on enabled cycles, restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (clear) begin
      r_cnt <= 4'd0;
    end else if (en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/tdm_mux8_tx.sv
// 8-slot TDM transmitter: captures an 8-bit frame and serialises it slot by
// slot onto a_out/s_out/e_out, each slot held for HOLD_CYCLES enabled cycles.
// Optional parity output p_out is enabled by defining TDM_MUX8_TX_PARITY_EN.
module tdm_mux8_tx
  import tdm_mux8_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [7:0]        din,
  output logic              ready,
  output logic              a_out,
  output logic [SLOT_W-1:0] s_out,
  output logic              e_out,
`ifdef TDM_MUX8_TX_PARITY_EN
  output logic              frame_done,
  output logic              p_out
`else
  output logic              frame_done
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_data;
  logic [7:0]        w_data_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              r_ready;
  logic              r_a_out;
  logic              r_e_out;
  logic              r_frame_done;
  logic              w_hold_clr;
  logic              w_hold_inc;
  logic              w_hold_tc;

  tdm_hold_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_hold_inc),
    .clear (w_hold_clr),
    .tc    (w_hold_tc)
  );

  // Next-state, next-slot, frame capture and hold-counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_data_nxt  = r_data;
    w_hold_clr  = 1'b1;
    w_hold_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load && en) begin
          w_state_nxt = SEND;
          w_slot_nxt  = '0;
          w_data_nxt  = din;
        end
      end
      SEND: begin
        if (en) begin
          if (w_hold_tc) begin
            if (r_slot == LAST_SLOT) begin
              w_state_nxt = DONE;
              w_slot_nxt  = '0;
            end else begin
              w_slot_nxt  = r_slot + 1'b1;
            end
          end else begin
            w_hold_clr = 1'b0;
            w_hold_inc = 1'b1;
          end
        end else begin
          // Paused: hold counter keeps its value.
          w_hold_clr = 1'b0;
        end
      end
      DONE: begin
        if (load && en) begin
          w_state_nxt = SEND;
          w_slot_nxt  = '0;
          w_data_nxt  = din;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_slot_nxt  = '0;
      end
    endcase
  end

  // State, captured frame and slot index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= 8'd0;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Registered outputs computed from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready      <= 1'b1;
      r_a_out      <= 1'b0;
      r_e_out      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_ready      <= (w_state_nxt != SEND);
      r_a_out      <= (w_state_nxt == SEND) ? w_data_nxt[w_slot_nxt] : 1'b0;
      r_e_out      <= (w_state_nxt == SEND) && en;
      r_frame_done <= (w_state_nxt == DONE);
    end
  end

  assign ready      = r_ready;
  assign a_out      = r_a_out;
  assign s_out      = r_slot;
  assign e_out      = r_e_out;
  assign frame_done = r_frame_done;

`ifdef TDM_MUX8_TX_PARITY_EN
  logic r_p_out;

  // Frame parity, presented only while the last slot is being strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_out <= 1'b0;
    end else begin
      r_p_out <= (w_state_nxt == SEND) && (w_slot_nxt == LAST_SLOT) && en
                 ? (^w_data_nxt) : 1'b0;
    end
  end

  assign p_out = r_p_out;
`endif

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Directed self-checking bench for tdm_mux8_tx: one instance with
// HOLD_CYCLES=1 (u1) and one with HOLD_CYCLES=3 (u3) sharing all inputs.
module tb_tdm_mux8_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] din;

  logic       rdy1, a1, e1, fd1;
  logic [2:0] s1;
  logic       rdy3, a3, e3, fd3;
  logic [2:0] s3;
`ifdef TDM_MUX8_TX_PARITY_EN
  logic       p1, p3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_mux8_tx #(.HOLD_CYCLES(1)) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .ready      (rdy1),
    .a_out      (a1),
    .s_out      (s1),
    .e_out      (e1),
`ifdef TDM_MUX8_TX_PARITY_EN
    .frame_done (fd1),
    .p_out      (p1)
`else
    .frame_done (fd1)
`endif
  );

  tdm_mux8_tx #(.HOLD_CYCLES(3)) u3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .ready      (rdy3),
    .a_out      (a3),
    .s_out      (s3),
    .e_out      (e3),
`ifdef TDM_MUX8_TX_PARITY_EN
    .frame_done (fd3),
    .p_out      (p3)
`else
    .frame_done (fd3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    #2;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%b expected=1", rdy1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL reset_e_out actual=%b expected=0", e1); end
    checks++; if (s1 !== 3'd0) begin errors++; $display("FAIL reset_s_out actual=%0d expected=0", s1); end
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL reset_a_out actual=%b expected=0", a1); end
    checks++; if (fd1 !== 1'b0) begin errors++; $display("FAIL reset_frame_done actual=%b expected=0", fd1); end
    checks++; if ({rdy3, e3, s3, a3, fd3} !== 7'b1_0_000_0_0) begin errors++; $display("FAIL reset_u3 actual=%b expected=1000000", {rdy3, e3, s3, a3, fd3}); end
    do_reset();
  endtask

  task automatic test_en_block();
    do_reset();
    en   = 1'b0;
    load = 1'b1;
    din  = 8'hFF;
    tick();
    tick();
    checks++; if (rdy1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL en_block_idle actual=rdy%b_e%b expected=rdy1_e0", rdy1, e1); end
    load = 1'b0;
    en   = 1'b1;
    tick();
    checks++; if (rdy1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL en_block_noload actual=rdy%b_e%b expected=rdy1_e0", rdy1, e1); end
  endtask

  task automatic test_frame_a5();
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    do_reset();
    din  = 8'hA5;
    load = 1'b1;
    tick();
    load = 1'b0;
    din  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++; if (s1 !== 3'(i)) begin errors++; $display("FAIL a5_s_out slot%0d actual=%0d expected=%0d", i, s1, i); end
      checks++; if (a1 !== exp_bits[i]) begin errors++; $display("FAIL a5_a_out slot%0d actual=%b expected=%b", i, a1, exp_bits[i]); end
      checks++; if (e1 !== 1'b1 || rdy1 !== 1'b0) begin errors++; $display("FAIL a5_e_rdy slot%0d actual=e%b_r%b expected=e1_r0", i, e1, rdy1); end
      tick();
    end
    checks++; if (fd1 !== 1'b1 || e1 !== 1'b0 || rdy1 !== 1'b1) begin errors++; $display("FAIL a5_done actual=fd%b_e%b_r%b expected=fd1_e0_r1", fd1, e1, rdy1); end
    tick();
    checks++; if (fd1 !== 1'b0 || rdy1 !== 1'b1) begin errors++; $display("FAIL a5_idle actual=fd%b_r%b expected=fd0_r1", fd1, rdy1); end
  endtask

  task automatic test_hold3();
    do_reset();
    din  = 8'h01;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int sl = 0; sl < 8; sl++) begin
      for (int h = 0; h < 3; h++) begin
        checks++; if (s3 !== 3'(sl) || e3 !== 1'b1) begin errors++; $display("FAIL hold3_slot s%0d h%0d actual=s%0d_e%b expected=s%0d_e1", sl, h, s3, e3, sl); end
        checks++; if (a3 !== (sl == 0)) begin errors++; $display("FAIL hold3_a_out s%0d h%0d actual=%b expected=%b", sl, h, a3, (sl == 0)); end
        tick();
      end
    end
    checks++; if (fd3 !== 1'b1 || e3 !== 1'b0) begin errors++; $display("FAIL hold3_done actual=fd%b_e%b expected=fd1_e0", fd3, e3); end
    tick();
    checks++; if (fd3 !== 1'b0) begin errors++; $display("FAIL hold3_done_pulse actual=%b expected=0", fd3); end
  endtask

  task automatic test_pause();
    do_reset();
    din  = 8'h10;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (s3 !== 3'd4 || a3 !== 1'b1 || e3 !== 1'b1) begin errors++; $display("FAIL pause_at_slot4 actual=s%0d_a%b_e%b expected=s4_a1_e1", s3, a3, e3); end
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s3 !== 3'd4 || e3 !== 1'b0 || a3 !== 1'b1) begin errors++; $display("FAIL pause_frozen c%0d actual=s%0d_e%b_a%b expected=s4_e0_a1", i, s3, e3, a3); end
    end
    en = 1'b1;
    tick();
    checks++; if (s3 !== 3'd4 || e3 !== 1'b1) begin errors++; $display("FAIL pause_resume actual=s%0d_e%b expected=s4_e1", s3, e3); end
    tick();
    checks++; if (s3 !== 3'd5 || a3 !== 1'b0 || e3 !== 1'b1) begin errors++; $display("FAIL pause_next_slot actual=s%0d_a%b_e%b expected=s5_a0_e1", s3, a3, e3); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1;
    logic [7:0] f2;
    f1 = 8'h0F;
    f2 = 8'h3C;
    do_reset();
    din  = 8'h0F;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (a1 !== f1[i] || rdy1 !== 1'b0 || s1 !== 3'(i)) begin errors++; $display("FAIL ignore_load slot%0d actual=a%b_r%b_s%0d expected=a%b_r0_s%0d", i, a1, rdy1, s1, f1[i], i); end
      din  = 8'hFF;
      load = (i < 7);
      tick();
    end
    din  = 8'h3C;
    load = 1'b1;
    checks++; if (fd1 !== 1'b1 || rdy1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL b2b_done actual=fd%b_r%b_e%b expected=fd1_r1_e0", fd1, rdy1, e1); end
    tick();
    load = 1'b0;
    din  = 8'h00;
    checks++; if (fd1 !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse actual=%b expected=0", fd1); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (a1 !== f2[i] || s1 !== 3'(i) || e1 !== 1'b1) begin errors++; $display("FAIL b2b_frame slot%0d actual=a%b_s%0d_e%b expected=a%b_s%0d_e1", i, a1, s1, e1, f2[i], i); end
      tick();
    end
    checks++; if (fd1 !== 1'b1) begin errors++; $display("FAIL b2b_second_done actual=%b expected=1", fd1); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    din  = 8'hFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (s1 !== 3'd6) begin errors++; $display("FAIL midrst_reach actual=%0d expected=6", s1); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rdy1, e1, s1, a1, fd1} !== 7'b1_0_000_0_0) begin errors++; $display("FAIL midrst_immediate actual=%b expected=1000000", {rdy1, e1, s1, a1, fd1}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fd1 !== 1'b0 || e1 !== 1'b0) begin errors++; $display("FAIL midrst_hold c%0d actual=fd%b_e%b expected=fd0_e0", i, fd1, e1); end
    end
    rst_n = 1'b1;
    tick();
    checks++; if (fd1 !== 1'b0 || rdy1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL midrst_idle actual=fd%b_r%b_e%b expected=fd0_r1_e0", fd1, rdy1, e1); end
    din  = 8'h81;
    load = 1'b1;
    tick();
    load = 1'b0;
    checks++; if (s1 !== 3'd0 || a1 !== 1'b1 || e1 !== 1'b1) begin errors++; $display("FAIL midrst_restart actual=s%0d_a%b_e%b expected=s0_a1_e1", s1, a1, e1); end
  endtask

`ifdef TDM_MUX8_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    din  = 8'h07;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL parity_slot6 actual=%b expected=0", p1); end
    tick();
    checks++; if (p1 !== 1'b1 || s1 !== 3'd7) begin errors++; $display("FAIL parity_07 actual=p%b_s%0d expected=p1_s7", p1, s1); end
    tick();
    checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL parity_done actual=%b expected=0", p1); end
    tick();
    din  = 8'h03;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (p1 !== 1'b0 || s1 !== 3'd7) begin errors++; $display("FAIL parity_03 actual=p%b_s%0d expected=p0_s7", p1, s1); end
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    #3;
    test_reset();
    test_en_block();
    test_frame_a5();
    test_hold3();
    test_pause();
    test_back_to_back();
    test_reset_midframe();
`ifdef TDM_MUX8_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux8_tx.md
TDM_MUX8_TX -- requirements
Module: tdm_mux8_tx

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter: HOLD_CYCLES, default 1, number of clock cycles each slot is driven (legal range 1..15).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: en  input  1  global enable; low pauses transmission.
REQ-006 Port: load  input  1  request to capture din and start a frame.
REQ-007 Port: din  input  8  parallel frame, bit i goes to slot i.
REQ-008 Port: ready  output  1  high when a load will be accepted.
REQ-009 Port: a_out  output  1  serial data bit for the current slot (feeds demux data input).
REQ-010 Port: s_out  output  3  current slot index (feeds demux select).
REQ-011 Port: e_out  output  1  slot-valid strobe (feeds demux enable).
REQ-012 Port: frame_done  output  1  one-cycle pulse after slot 7 completes.

Function
REQ-013 The FSM SHALL have states IDLE, SEND and DONE.
REQ-014 In IDLE, ready SHALL be 1, e_out 0, s_out 0 and a_out 0.
REQ-015 A load is accepted on a rising edge with load=1, en=1 and ready=1; din SHALL be captured into an 8-bit shift/hold register in that edge.
REQ-016 Latency: in the cycle after acceptance, the FSM SHALL be in SEND with e_out=1, s_out=0, a_out=din[0].
REQ-017 Each slot i SHALL be held for exactly HOLD_CYCLES enabled cycles with s_out=i and a_out=captured bit i; then s_out increments by 1.
REQ-018 After slot 7's last hold cycle, the FSM SHALL enter DONE for exactly one cycle: frame_done=1, e_out=0, ready=1.
REQ-019 In DONE, a valid load SHALL be accepted (back-to-back frames), giving slot 0 of the new frame in the next cycle; otherwise the FSM returns to IDLE.
REQ-020 In SEND, ready SHALL be 0 and load SHALL be ignored; the captured frame is unaffected by din changes.
REQ-021 en=0 during SEND SHALL freeze state, slot index, hold counter and a_out; e_out SHALL be 0 while paused; transmission resumes in the same slot when en returns to 1.
REQ-022 en=0 in IDLE or DONE SHALL block load acceptance; in DONE, frame_done still pulses and the FSM returns to IDLE.
REQ-023 The slot counter SHALL NOT wrap past 7 within a frame; the transition from 7 goes to DONE only.
REQ-024 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, ready=1, e_out=0, s_out=0, a_out=0, frame_done=0, clear the data, slot and hold registers, and set p_out=0 when parity is enabled.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; the first edge after release SHALL behave as IDLE.

Configuration
REQ-027 Macro TDM_MUX8_TX_PARITY_EN SHALL add an output p_out (1 bit) that equals the XOR of the captured frame, is valid while s_out=7 and e_out=1, and is 0 otherwise.
REQ-028 Without TDM_MUX8_TX_PARITY_EN, the p_out port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package tdm_mux8_pkg SHALL hold the state enum (IDLE/SEND/DONE), SLOT_COUNT=8 and SLOT_W=3.
REQ-030 The hold counter SHALL be a sub-module, tdm_hold_cnt, with clk, rst_n, en, clear and a terminal-count output.

Verification
REQ-031 HOLD_CYCLES=1, en=1, load with din=8'hA5 -> over 8 cycles s_out=0..7, a_out=1,0,1,0,0,1,0,1, then frame_done=1 for one cycle.
REQ-032 HOLD_CYCLES=3, din=8'h01 -> each s_out value is held 3 cycles; a_out=1 only during slot 0; frame spans 24 cycles plus 1 DONE cycle.
REQ-033 en dropped for 5 cycles at slot 4 -> e_out=0 and s_out=4 are frozen; on resume, slot 4 completes its remaining hold cycles, then slot 5 follows.
REQ-034 load of 8'hFF during SEND of frame 8'h0F -> ignored, output stays 8'h0F; load of 8'h3C in the DONE cycle -> slot 0 of 8'h3C in the next cycle.
REQ-035 rst_n pulsed low at slot 6 -> outputs go to reset values immediately, no frame_done; after release a new load starts at slot 0.
REQ-036 With TDM_MUX8_TX_PARITY_EN, din=8'h07 -> p_out=1 during slot 7; din=8'h03 -> p_out=0.
